// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC and the fetch/drain state encoding.
package pc_fetch_unit_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          INSTR_W  = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between the memory response
// side and decode. Flush empties it in one cycle and overrides push/pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_push;
    logic w_pop;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign w_push = push && (!full || pop);
    assign w_pop  = pop && !empty;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by the pointers, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC sequencing, imem request/response handling and decode handoff,
// with redirect flush and stale-response dropping. Optional FETCH_BYPASS_EN.
module pc_fetch_unit #(
    parameter int              XLEN       = pc_fetch_unit_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(pc_fetch_unit_pkg::RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 redirect_valid,
    input  logic [XLEN-1:0]                      redirect_pc,
    output logic                                 imem_req_valid,
    input  logic                                 imem_req_ready,
    output logic [XLEN-1:0]                      imem_req_addr,
    input  logic                                 imem_rsp_valid,
    input  logic [pc_fetch_unit_pkg::INSTR_W-1:0] imem_rsp_data,
    output logic                                 if_valid,
    input  logic                                 if_ready,
    output logic [XLEN-1:0]                      if_pc,
    output logic [pc_fetch_unit_pkg::INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]                      if_pc_plus4
);

    import pc_fetch_unit_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    fetch_state_t    r_state;

    logic [CW:0]     w_inflight;
    logic [CW-1:0]   w_out_after_rsp;
    logic [CW-1:0]   w_count;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_rsp_accept;
    logic            w_buf_valid;
    logic            w_bypass;
    logic            w_fifo_push;
    logic            w_fifo_pop;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_if_entry;

    // Outstanding plus buffered never exceeds the buffer size, so every
    // accepted response is guaranteed a slot.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count};
    assign imem_req_valid = !rst && !redirect_valid && (w_inflight < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_out_after_rsp = r_outstanding - CW'(imem_rsp_valid);
    assign w_rsp_accept    = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
    assign w_redirect_pc   = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_BYPASS_EN
    assign w_bypass = !rst && w_empty && (r_state == FETCH) && imem_rsp_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_buf_valid  = !w_empty && (r_state == FETCH);
    assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};
    assign w_if_entry   = w_buf_valid ? w_head : (w_bypass ? w_push_entry : '0);

    assign if_valid    = w_buf_valid || w_bypass;
    assign if_pc       = w_if_entry.pc;
    assign if_instr    = w_if_entry.instr;
    assign if_pc_plus4 = if_pc + XLEN'(4);

    assign w_fifo_pop  = w_buf_valid && if_ready;
    assign w_fifo_push = w_rsp_accept && !(w_bypass && if_ready);

    fetch_fifo #(
        .WIDTH (XLEN + INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_fifo_push),
        .push_data (w_push_entry),
        .pop       (w_fifo_pop),
        .flush     (redirect_valid),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_state       <= FETCH;
        end else begin
            r_outstanding <= w_out_after_rsp + CW'(w_req_fire);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                r_pc       <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop_cnt <= w_out_after_rsp;
                r_state    <= (w_out_after_rsp != '0) ? DRAIN : FETCH;
            end else begin
                if (w_req_fire)   r_pc     <= r_pc + XLEN'(4);
                if (w_rsp_accept) r_rsp_pc <= r_rsp_pc + XLEN'(4);
                if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                    if (r_drop_cnt == CW'(1)) r_state <= FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (redirect_valid || !(w_fifo_push && w_full && !w_fifo_pop));
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an in-order memory model and a
// scoreboard of expected {pc, instr} pairs for decode.
module tb_pc_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] pop_log[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          epoch = 0;
    int          mark = 0;
    logic [31:0] m_pc = RST_PC;
    bit          arm_redirect = 1'b0;
    logic [31:0] arm_pc = '0;
    bit          armed_hit = 1'b0;
    bit          saw_wrap = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5EED_C0DE;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input int idx, input logic [31:0] exp);
        if (idx < pop_log.size()) check(tag, pop_log[idx], exp);
        else check({tag, "_count"}, pop_log.size(), idx + 1);
    endtask

    // One clock: drive memory response, evaluate mid-cycle, update the model.
    task automatic cycle();
        bit          have_rsp;
        bit          rsp_stale;
        bit          exp_vld;
        exp_t        e;
        logic [31:0] nxt;
        have_rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = have_rsp;
        imem_rsp_data  = have_rsp ? instr_of(mem_q[0].addr) : '0;
        if (arm_redirect && have_rsp && if_ready && exp_q.size() > 0) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm_redirect   = 1'b0;
            armed_hit      = 1'b1;
        end
        @(negedge clk);
        rsp_stale = have_rsp && (mem_q[0].epoch != epoch);
        exp_vld = (exp_q.size() > 0);
`ifdef FETCH_BYPASS_EN
        exp_vld = exp_vld || (have_rsp && !rsp_stale);
`endif
        check("if_valid", if_valid, exp_vld);
        check("occupancy_bound", 64'(mem_q.size() + exp_q.size() <= DEPTH), 1);
        if (have_rsp) begin
            if (!redirect_valid && !rsp_stale)
                exp_q.push_back('{pc: mem_q[0].addr, instr: instr_of(mem_q[0].addr)});
            void'(mem_q.pop_front());
        end
        if (if_valid && if_ready && !redirect_valid) begin
            check("sb_nonempty", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nxt = e.pc + 32'd4;
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
                check("if_pc_plus4", if_pc_plus4, nxt);
                if (e.pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            end
            pop_log.push_back(if_pc);
        end
        if (redirect_valid) begin
            check("req_blocked_on_redirect", imem_req_valid, 0);
        end else if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, m_pc);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat, epoch: epoch});
            m_pc += 32'd4;
        end
        if (redirect_valid) begin
            epoch++;
            exp_q.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 0);

        // Straight-line stream, 1-cycle memory, decode always ready.
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        repeat (12) cycle();
        check("stream_progress", 64'(pop_log.size() >= 4), 1);
        check_pop("stream_pc0", 0, 32'h0);
        check_pop("stream_pc2", 2, 32'h8);

        // Decode stalls: buffer fills, requests stop at the bound.
        if_ready = 1'b0;
        repeat (10) cycle();
        check("stall_buffer_full", exp_q.size(), DEPTH);
        if_ready = 1'b1;
        repeat (10) cycle();

        // Redirect with two requests in flight.
        mem_lat = 3;
        for (int i = 0; i < 40 && mem_q.size() < 2; i++) cycle();
        check("two_in_flight", mem_q.size(), 2);
        mark = pop_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        cycle();
        mem_lat = 1;
        repeat (12) cycle();
        check_pop("redirect_first", mark, 32'h100);
        check_pop("redirect_second", mark + 1, 32'h104);

        // Misaligned target, redirect coinciding with a response and a pop.
        arm_redirect = 1'b1;
        arm_pc = 32'h0000_0203;
        for (int i = 0; i < 30 && !armed_hit; i++) cycle();
        check("redirect_rsp_pop_hit", armed_hit, 1);
        mark = pop_log.size();
        repeat (10) cycle();
        check_pop("aligned_target", mark, 32'h200);

        // PC wrap at the top of the address space.
        mark = pop_log.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        repeat (10) cycle();
        check("saw_wrap", saw_wrap, 1);
        check_pop("wrap_last", mark, 32'hFFFF_FFFC);
        check_pop("wrap_zero", mark + 1, 32'h0);

        // Reset mid-stream with the buffer full.
        if_ready = 1'b0;
        for (int i = 0; i < 30 && exp_q.size() < DEPTH; i++) cycle();
        check("full_before_reset", exp_q.size(), DEPTH);
        #2;
        rst = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        check("async_rst_if_valid", if_valid, 0);
        check("async_rst_req_valid", imem_req_valid, 0);
        mem_q.delete();
        exp_q.delete();
        epoch++;
        m_pc = RST_PC;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_ready = 1'b1;
        mark = pop_log.size();
        repeat (10) cycle();
        check_pop("restart_pc", mark, RST_PC);
        check_pop("restart_next", mark + 1, RST_PC + 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
